// File: rtl/lc3_control.sv
// LC-3 multicycle control FSM: fetch / decode / execute sequencing and datapath strobes.
// Optional TRAP support is compiled in with the LC3_TRAP_EN macro; without it opcode 1111 halts.
module lc3_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic [2:0]  nzp,
  input  logic        mem_rdy,
  output logic [1:0]  aluControl,
  output logic        enaALU,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        logicWE,
  output logic [1:0]  selPC,
  output logic        enaMARM,
  output logic        selMAR,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        enaPC,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        flagWE,
  output logic        enaMDR,
  output logic        mem_en,
  output logic        mem_we,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_FETCH_MAR,
    S_FETCH_MEM,
    S_FETCH_IR,
    S_DECODE,
    S_EXEC_ALU,
    S_EXEC_BR,
    S_EXEC_JMP,
    S_EXEC_LEA,
    S_ADDR_CALC,
    S_LD_MEM,
    S_LD_WB,
    S_ST_MDR,
    S_ST_MEM,
`ifdef LC3_TRAP_EN
    S_TRAP_R7,
    S_TRAP_MAR,
    S_TRAP_MEM,
    S_TRAP_PC,
`endif
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_TRP = 4'b1111;

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       br_taken;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign br_taken  = |(IR[11:9] & nzp);
  assign unused_ir = ^IR[5:3];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH_MAR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_MAR: state_d = S_FETCH_MEM;
      S_FETCH_MEM: if (mem_rdy) state_d = S_FETCH_IR;
      S_FETCH_IR:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: state_d = S_EXEC_ALU;
          OP_BR:                  state_d = S_EXEC_BR;
          OP_JMP:                 state_d = S_EXEC_JMP;
          OP_LEA:                 state_d = S_EXEC_LEA;
          OP_LD, OP_LDR,
          OP_ST, OP_STR:          state_d = S_ADDR_CALC;
`ifdef LC3_TRAP_EN
          OP_TRP:                 state_d = S_TRAP_R7;
`endif
          default:                state_d = S_HALT;
        endcase
      end
      S_EXEC_ALU,
      S_EXEC_BR,
      S_EXEC_JMP,
      S_EXEC_LEA:  state_d = S_FETCH_MAR;
      // LD/LDR have opcode bit 0 clear, ST/STR have it set
      S_ADDR_CALC: state_d = opcode[0] ? S_ST_MDR : S_LD_MEM;
      S_LD_MEM:    if (mem_rdy) state_d = S_LD_WB;
      S_LD_WB:     state_d = S_FETCH_MAR;
      S_ST_MDR:    state_d = S_ST_MEM;
      S_ST_MEM:    if (mem_rdy) state_d = S_FETCH_MAR;
`ifdef LC3_TRAP_EN
      S_TRAP_R7:   state_d = S_TRAP_MAR;
      S_TRAP_MAR:  state_d = S_TRAP_MEM;
      S_TRAP_MEM:  if (mem_rdy) state_d = S_TRAP_PC;
      S_TRAP_PC:   state_d = S_FETCH_MAR;
`endif
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH_MAR;
    endcase
  end

  always_comb begin
    aluControl = 2'b00;
    enaALU     = 1'b0;
    SR1        = 3'd0;
    SR2        = 3'd0;
    DR         = 3'd0;
    logicWE    = 1'b0;
    selPC      = 2'b00;
    enaMARM    = 1'b0;
    selMAR     = 1'b0;
    selEAB1    = 1'b0;
    selEAB2    = 2'b00;
    enaPC      = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    selMDR     = 1'b0;
    flagWE     = 1'b0;
    enaMDR     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    // Reset gates every output, so a pending memory request drops in the same cycle
    if (rst) begin
      case (state_q)
        S_FETCH_MAR: begin
          enaPC = 1'b1;
          ldMAR = 1'b1;
          ldPC  = 1'b1;
          selPC = 2'b00;
        end
`ifdef LC3_TRAP_EN
        S_TRAP_MEM,
`endif
        S_FETCH_MEM,
        S_LD_MEM: begin
          mem_en = 1'b1;
          ldMDR  = mem_rdy;
          selMDR = mem_rdy;
        end
        S_FETCH_IR: begin
          enaMDR = 1'b1;
          ldIR   = 1'b1;
        end
        S_EXEC_ALU: begin
          case (opcode)
            OP_ADD:  aluControl = 2'b01;
            OP_AND:  aluControl = 2'b10;
            default: aluControl = 2'b11;
          endcase
          SR1     = IR[8:6];
          SR2     = IR[2:0];
          DR      = IR[11:9];
          enaALU  = 1'b1;
          logicWE = 1'b1;
          flagWE  = 1'b1;
        end
        S_EXEC_BR: begin
          if (br_taken) begin
            selEAB1 = 1'b0;
            selEAB2 = 2'b10;
            selPC   = 2'b01;
            ldPC    = 1'b1;
          end
        end
        S_EXEC_JMP: begin
          SR1     = IR[8:6];
          selEAB1 = 1'b1;
          selEAB2 = 2'b00;
          selPC   = 2'b01;
          ldPC    = 1'b1;
        end
        S_EXEC_LEA: begin
          selEAB1 = 1'b0;
          selEAB2 = 2'b10;
          selMAR  = 1'b0;
          enaMARM = 1'b1;
          DR      = IR[11:9];
          logicWE = 1'b1;
        end
        S_ADDR_CALC: begin
          enaMARM = 1'b1;
          selMAR  = 1'b0;
          ldMAR   = 1'b1;
          if (opcode == OP_LD || opcode == OP_ST) begin
            selEAB1 = 1'b0;
            selEAB2 = 2'b10;
          end else begin
            selEAB1 = 1'b1;
            SR1     = IR[8:6];
            selEAB2 = 2'b01;
          end
        end
        S_LD_WB: begin
          enaMDR  = 1'b1;
          DR      = IR[11:9];
          logicWE = 1'b1;
          flagWE  = 1'b1;
        end
        S_ST_MDR: begin
          SR1        = IR[11:9];
          aluControl = 2'b00;
          enaALU     = 1'b1;
          ldMDR      = 1'b1;
          selMDR     = 1'b0;
        end
        S_ST_MEM: begin
          mem_en = 1'b1;
          mem_we = 1'b1;
        end
`ifdef LC3_TRAP_EN
        S_TRAP_R7: begin
          enaPC   = 1'b1;
          DR      = 3'd7;
          logicWE = 1'b1;
        end
        S_TRAP_MAR: begin
          selMAR  = 1'b1;
          enaMARM = 1'b1;
          ldMAR   = 1'b1;
        end
        S_TRAP_PC: begin
          enaMDR = 1'b1;
          selPC  = 2'b10;
          ldPC   = 1'b1;
        end
`endif
        S_HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_control.sv
// Randomized scoreboard bench for lc3_control; the reference is a per-opcode micro-op list.
module tb_lc3_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic [2:0]  nzp;
  logic        mem_rdy;
  logic [1:0]  aluControl, selPC, selEAB2;
  logic [2:0]  SR1, SR2, DR;
  logic        enaALU, logicWE, enaMARM, selMAR, selEAB1, enaPC, ldPC, ldIR, ldMAR;
  logic        ldMDR, selMDR, flagWE, enaMDR, mem_en, mem_we, halted;

  lc3_control dut (
    .clk(clk), .rst(rst), .IR(IR), .nzp(nzp), .mem_rdy(mem_rdy),
    .aluControl(aluControl), .enaALU(enaALU), .SR1(SR1), .SR2(SR2), .DR(DR),
    .logicWE(logicWE), .selPC(selPC), .enaMARM(enaMARM), .selMAR(selMAR),
    .selEAB1(selEAB1), .selEAB2(selEAB2), .enaPC(enaPC), .ldPC(ldPC), .ldIR(ldIR),
    .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .flagWE(flagWE), .enaMDR(enaMDR),
    .mem_en(mem_en), .mem_we(mem_we), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       halted;
    logic [1:0] alu;
    logic       ena_alu;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       reg_we;
    logic [1:0] sel_pc;
    logic       ena_marm;
    logic       sel_mar;
    logic       sel_eab1;
    logic [1:0] sel_eab2;
    logic       ena_pc;
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_mar;
    logic       ld_mdr;
    logic       sel_mdr;
    logic       flag_we;
    logic       ena_mdr;
    logic       mem_en;
    logic       mem_we;
  } outs_t;

  typedef enum int {
    U_FMAR, U_FMEM, U_FIR, U_DEC, U_ALU, U_BR, U_JMP, U_LEA, U_ADDR, U_LDMEM,
    U_LDWB, U_STMDR, U_STMEM, U_TR7, U_TMAR, U_TMEM, U_TPC, U_HALT, U_RST
  } uop_e;

  outs_t act;
  outs_t exp_q[$];
  int    tag_q[$];
  int    total = 0;
  int    bad = 0;
  logic [15:0] cur_ir = 16'h0;
  logic [2:0]  cur_nzp = 3'b0;

  always_comb begin
    act.halted   = halted;
    act.alu      = aluControl;
    act.ena_alu  = enaALU;
    act.sr1      = SR1;
    act.sr2      = SR2;
    act.dr       = DR;
    act.reg_we   = logicWE;
    act.sel_pc   = selPC;
    act.ena_marm = enaMARM;
    act.sel_mar  = selMAR;
    act.sel_eab1 = selEAB1;
    act.sel_eab2 = selEAB2;
    act.ena_pc   = enaPC;
    act.ld_pc    = ldPC;
    act.ld_ir    = ldIR;
    act.ld_mar   = ldMAR;
    act.ld_mdr   = ldMDR;
    act.sel_mdr  = selMDR;
    act.flag_we  = flagWE;
    act.ena_mdr  = enaMDR;
    act.mem_en   = mem_en;
    act.mem_we   = mem_we;
  end

  function automatic outs_t expect_out(uop_e u, logic [15:0] ir, logic [2:0] cc, logic rdy);
    outs_t o;
    logic [3:0] op;
    o  = '0;
    op = ir[15:12];
    case (u)
      U_FMAR: begin o.ena_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
      U_FMEM, U_LDMEM, U_TMEM: begin o.mem_en = 1; o.ld_mdr = rdy; o.sel_mdr = rdy; end
      U_FIR: begin o.ena_mdr = 1; o.ld_ir = 1; end
      U_ALU: begin
        o.alu = (op == 4'd1) ? 2'b01 : (op == 4'd5) ? 2'b10 : 2'b11;
        o.sr1 = ir[8:6]; o.sr2 = ir[2:0]; o.dr = ir[11:9];
        o.ena_alu = 1; o.reg_we = 1; o.flag_we = 1;
      end
      U_BR: if ((ir[11:9] & cc) != 3'b0) begin o.sel_eab2 = 2'b10; o.sel_pc = 2'b01; o.ld_pc = 1; end
      U_JMP: begin o.sr1 = ir[8:6]; o.sel_eab1 = 1; o.sel_pc = 2'b01; o.ld_pc = 1; end
      U_LEA: begin o.sel_eab2 = 2'b10; o.ena_marm = 1; o.dr = ir[11:9]; o.reg_we = 1; end
      U_ADDR: begin
        o.ena_marm = 1; o.ld_mar = 1;
        if (op == 4'd2 || op == 4'd3) o.sel_eab2 = 2'b10;
        else begin o.sel_eab1 = 1; o.sr1 = ir[8:6]; o.sel_eab2 = 2'b01; end
      end
      U_LDWB: begin o.ena_mdr = 1; o.dr = ir[11:9]; o.reg_we = 1; o.flag_we = 1; end
      U_STMDR: begin o.sr1 = ir[11:9]; o.ena_alu = 1; o.ld_mdr = 1; end
      U_STMEM: begin o.mem_en = 1; o.mem_we = 1; end
      U_TR7: begin o.ena_pc = 1; o.dr = 3'd7; o.reg_we = 1; end
      U_TMAR: begin o.sel_mar = 1; o.ena_marm = 1; o.ld_mar = 1; end
      U_TPC: begin o.ena_mdr = 1; o.sel_pc = 2'b10; o.ld_pc = 1; end
      U_HALT: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic step(input logic r, input logic rdy, input uop_e u);
    @(negedge clk);
    rst     = r;
    mem_rdy = rdy;
    IR      = cur_ir;
    nzp     = cur_nzp;
    exp_q.push_back(r ? expect_out(u, cur_ir, cur_nzp, rdy) : outs_t'('0));
    tag_q.push_back(int'(u));
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic mem_phase(input uop_e u, input int waits);
    repeat (waits) step(1'b1, 1'b0, u);
    step(1'b1, 1'b1, u);
  endtask

  task automatic halt_seq();
    repeat (3) step(1'b1, rnd(), U_HALT);
    step(1'b0, rnd(), U_RST);
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [2:0] cc,
                           input int fw, input int dw, input bit abort);
    cur_ir  = ir;
    cur_nzp = cc;
    step(1'b1, rnd(), U_FMAR);
    if (abort) begin
      step(1'b1, 1'b0, U_FMEM);
      step(1'b0, rnd(), U_RST);
      step(1'b0, rnd(), U_RST);
      return;
    end
    mem_phase(U_FMEM, fw);
    step(1'b1, rnd(), U_FIR);
    step(1'b1, rnd(), U_DEC);
    case (ir[15:12])
      4'd1, 4'd5, 4'd9: step(1'b1, rnd(), U_ALU);
      4'd0:  step(1'b1, rnd(), U_BR);
      4'd12: step(1'b1, rnd(), U_JMP);
      4'd14: step(1'b1, rnd(), U_LEA);
      4'd2, 4'd6: begin
        step(1'b1, rnd(), U_ADDR);
        mem_phase(U_LDMEM, dw);
        step(1'b1, rnd(), U_LDWB);
      end
      4'd3, 4'd7: begin
        step(1'b1, rnd(), U_ADDR);
        step(1'b1, rnd(), U_STMDR);
        mem_phase(U_STMEM, dw);
      end
`ifdef LC3_TRAP_EN
      4'd15: begin
        step(1'b1, rnd(), U_TR7);
        step(1'b1, rnd(), U_TMAR);
        mem_phase(U_TMEM, dw);
        step(1'b1, rnd(), U_TPC);
      end
`endif
      default: halt_seq();
    endcase
  endtask

  initial begin : monitor
    outs_t e;
    int    t;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL outputs uop=%0d ir=%h nzp=%b t=%0t got=%h want=%h",
                   t, IR, nzp, $time, act, e);
        end
      end
    end
  end

  initial begin : driver
    rst     = 1'b0;
    IR      = 16'h0;
    nzp     = 3'b0;
    mem_rdy = 1'b0;
    repeat (3) step(1'b0, rnd(), U_RST);
    run_instr(16'h12A3, 3'b000, 0, 0, 0);
    run_instr(16'h0405, 3'b010, 0, 0, 0);
    run_instr(16'h0405, 3'b100, 1, 0, 0);
    run_instr(16'h2205, 3'b001, 0, 3, 0);
    run_instr(16'h7442, 3'b000, 0, 2, 0);
    run_instr(16'h567F, 3'b000, 2, 0, 0);
    run_instr(16'h9A7F, 3'b000, 0, 0, 0);
    run_instr(16'hC1C0, 3'b000, 0, 0, 0);
    run_instr(16'hE9FF, 3'b000, 0, 0, 0);
    run_instr(16'h6A85, 3'b000, 1, 1, 0);
    run_instr(16'h3E10, 3'b000, 0, 1, 0);
    run_instr(16'h12A3, 3'b000, 0, 0, 1);
    run_instr(16'hF025, 3'b000, 0, 1, 0);
    run_instr(16'h4000, 3'b000, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      run_instr(16'($urandom()), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    #6;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
